// File: rtl/sort_floats_pkg.sv
// Shared types and constants for the streaming float sorter.
// FP64 constants are also used by the bench.
package sort_floats_pkg;

  localparam int FLEN  = 64;
  localparam int EXP_W = 11;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DRAIN
  } sort_state_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  localparam logic [63:0] FP64_ONE      = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] FP64_NEG_ZERO = 64'h8000_0000_0000_0000;
  localparam logic [63:0] FP64_QNAN     = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/f_less_or_equal.sv
// IEEE-754 a <= b compare; err flags a NaN operand.
// Signed zeros compare equal. res is forced low when err is set.
module f_less_or_equal #(
  parameter int FLEN  = 64,
  parameter int EXP_W = 11
) (
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            res,
  output logic            err
);
  localparam int MAN_W = FLEN - 1 - EXP_W;

  logic [FLEN-2:0] a_mag, b_mag;
  logic            a_neg, b_neg, a_nan, b_nan;

  assign a_mag = a[FLEN-2:0];
  assign b_mag = b[FLEN-2:0];
  assign a_neg = a[FLEN-1];
  assign b_neg = b[FLEN-1];
  assign a_nan = (&a[FLEN-2 -: EXP_W]) & (|a[MAN_W-1:0]);
  assign b_nan = (&b[FLEN-2 -: EXP_W]) & (|b[MAN_W-1:0]);
  assign err   = a_nan | b_nan;

  always_comb begin
    res = 1'b0;
    if (err)                         res = 1'b0;
    else if (~|a_mag && ~|b_mag)     res = 1'b1;
    else if (a_neg != b_neg)         res = a_neg;
    // Sign-magnitude: larger magnitude is smaller when negative.
    else if (a_neg)                  res = (a_mag >= b_mag);
    else                             res = (a_mag <= b_mag);
  end

endmodule

// File: rtl/sort_floats_step.sv
// One bubble-sort step: compares the current pair and says whether to swap.
// NaN and equal pairs never swap, which keeps the sort stable.
module sort_floats_step
  import sort_floats_pkg::*;
(
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            swap,
  output logic            cmp_err
);
  logic res;

  f_less_or_equal #(.FLEN(FLEN), .EXP_W(EXP_W)) u_cmp (
    .a   (a),
    .b   (b),
    .res (res),
    .err (cmp_err)
  );

  assign swap = ~res & ~cmp_err;

endmodule

// File: rtl/sort_floats_stream.sv
// Batch float sorter: load N values, bubble-sort in place, stream out ascending.
// Define SORT_FLOATS_EARLY_EXIT_EN to end SORT after a pass with no swaps.
module sort_floats_stream
  import sort_floats_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            up_valid,
  input  logic [FLEN-1:0] up_data,
  output logic            up_ready,
  output logic            down_valid,
  input  logic            down_ready,
  output logic [FLEN-1:0] down_data,
  output logic            down_last,
  output logic            err
);
  localparam int            IW       = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] LAST_CMP = IW'(N - 2);

  sort_state_t               state_q, state_d;
  logic [N-1:0][FLEN-1:0]    data_buf;
  logic [IW-1:0]             wr_idx, rd_idx, i_idx, i_nxt, p_cnt;
  logic [FLEN-1:0]           cmp_a, cmp_b;
  logic                      swap, cmp_err, acc, pop, pass_end, clean_pass, in_sort;

  assign i_nxt    = i_idx + 1'b1;
  assign cmp_a    = data_buf[i_idx];
  assign cmp_b    = data_buf[i_nxt];
  assign in_sort  = (state_q == S_SORT);
  assign pass_end = (i_idx == LAST_CMP);
  assign acc      = up_valid & up_ready;
  assign pop      = down_valid & down_ready;

  sort_floats_step u_step (
    .a       (cmp_a),
    .b       (cmp_b),
    .swap    (swap),
    .cmp_err (cmp_err)
  );

`ifdef SORT_FLOATS_EARLY_EXIT_EN
  logic swapped_q;

  // Includes the swap of the pass's final compare, which lands on the exit edge.
  assign clean_pass = ~(swapped_q | swap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          swapped_q <= 1'b0;
    else if (in_sort) swapped_q <= pass_end ? 1'b0 : (swapped_q | swap);
  end
`else
  assign clean_pass = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    down_data  = '0;
    down_last  = 1'b0;
    case (state_q)
      S_LOAD: begin
        up_ready = 1'b1;
        if (acc && wr_idx == LAST_IDX) state_d = S_SORT;
      end
      S_SORT: begin
        if (pass_end && (p_cnt == LAST_CMP || clean_pass)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        down_valid = 1'b1;
        down_data  = data_buf[rd_idx];
        down_last  = (rd_idx == LAST_IDX);
        if (pop && rd_idx == LAST_IDX) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      wr_idx  <= '0;
      rd_idx  <= '0;
      i_idx   <= '0;
      p_cnt   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
        if (wr_idx == '0) err <= 1'b0;
        if (wr_idx == LAST_IDX) begin
          i_idx <= '0;
          p_cnt <= '0;
        end
      end
      if (in_sort) begin
        err   <= err | cmp_err;
        i_idx <= pass_end ? '0 : i_nxt;
        if (pass_end) p_cnt <= (state_d == S_DRAIN) ? '0 : p_cnt + 1'b1;
      end
      if (pop) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
    end
  end

  // Load and swap never coincide: loads happen only in LOAD, swaps only in SORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_buf <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (acc && wr_idx == IW'(k))                 data_buf[k] <= up_data;
        else if (in_sort && swap && i_idx == IW'(k)) data_buf[k] <= cmp_b;
        else if (in_sort && swap && i_nxt == IW'(k)) data_buf[k] <= cmp_a;
      end
    end
  end

endmodule

// File: tb/tb_sort_floats_stream.sv
// Directed bench for sort_floats_stream (N=4): table of batches plus
// backpressure and mid-sort reset sequences.
module tb_sort_floats_stream;
  import sort_floats_pkg::*;

  localparam logic [63:0] P0 = 64'h0000_0000_0000_0000;
  localparam logic [63:0] M0 = FP64_NEG_ZERO;
  localparam logic [63:0] P1 = FP64_ONE;
  localparam logic [63:0] P2 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] P3 = 64'h4008_0000_0000_0000;
  localparam logic [63:0] P4 = 64'h4010_0000_0000_0000;
  localparam logic [63:0] M1 = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] QN = FP64_QNAN;

`ifdef SORT_FLOATS_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [3:0][63:0] din;
    logic [3:0][63:0] dout;
    logic             err;
    int               lat_fixed;
    int               lat_ee;
  } vec_t;

  logic        clk, rst, up_valid, up_ready, down_valid, down_ready, down_last, err;
  logic [63:0] up_data, down_data;

  int   n_chk = 0;
  int   n_bad = 0;
  vec_t vecs[6];

  sort_floats_stream #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .down_last  (down_last),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0][63:0] mk(input logic [63:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push4(input vec_t v, input string tag);
    up_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s up_ready[%0d]", tag, k), 64'(up_ready), 64'(1));
      up_data = v.din[k];
      @(posedge clk); #1;
      if (k == 0) chk($sformatf("%s err_clear", tag), 64'(err), 64'(0));
    end
    up_valid = 1'b0;
  endtask

  task automatic load_batch(input vec_t v, input string tag);
    int cyc;
    push4(v, tag);
    cyc = 0;
    while (!down_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("%s latency", tag), 64'(cyc), 64'(EE ? v.lat_ee : v.lat_fixed));
  endtask

  task automatic drain_from(input vec_t v, input int start, input string tag);
    for (int k = start; k < 4; k++) begin
      chk($sformatf("%s valid[%0d]", tag, k), 64'(down_valid), 64'(1));
      chk($sformatf("%s data[%0d]", tag, k), down_data, v.dout[k]);
      chk($sformatf("%s last[%0d]", tag, k), 64'(down_last), 64'(k == 3));
      chk($sformatf("%s err[%0d]", tag, k), 64'(err), 64'(v.err));
      chk($sformatf("%s up_ready_drain[%0d]", tag, k), 64'(up_ready), 64'(0));
      @(posedge clk); #1;
    end
    chk($sformatf("%s up_ready_after", tag), 64'(up_ready), 64'(1));
    chk($sformatf("%s valid_after", tag), 64'(down_valid), 64'(0));
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b1;

    vecs[0] = '{din: mk(P3, P1, P4, P2), dout: mk(P1, P2, P3, P4), err: 1'b0, lat_fixed: 9, lat_ee: 9};
    vecs[1] = '{din: mk(P1, P2, P3, P4), dout: mk(P1, P2, P3, P4), err: 1'b0, lat_fixed: 9, lat_ee: 3};
    vecs[2] = '{din: mk(P0, M0, M1, M1), dout: mk(M1, M1, P0, M0), err: 1'b0, lat_fixed: 9, lat_ee: 9};
    vecs[3] = '{din: mk(P2, QN, P1, P3), dout: mk(P2, QN, P1, P3), err: 1'b1, lat_fixed: 9, lat_ee: 3};
    vecs[4] = '{din: mk(P2, M1, P1, M0), dout: mk(M1, M0, P1, P2), err: 1'b0, lat_fixed: 9, lat_ee: 9};
    vecs[5] = '{din: mk(P4, P3, P2, P1), dout: mk(P1, P2, P3, P4), err: 1'b0, lat_fixed: 9, lat_ee: 9};

    #12;
    chk("reset up_ready", 64'(up_ready), 64'(1));
    chk("reset down_valid", 64'(down_valid), 64'(0));
    chk("reset down_data", down_data, 64'(0));
    chk("reset down_last", 64'(down_last), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) begin
      if (k > 0 && vecs[k-1].err)
        chk($sformatf("v%0d err_sticky_idle", k), 64'(err), 64'(1));
      load_batch(vecs[k], $sformatf("v%0d", k));
      drain_from(vecs[k], 0, $sformatf("v%0d", k));
    end

    // Backpressure: stall 5 cycles after the 2nd output.
    load_batch(vecs[0], "bp");
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("bp data[%0d]", k), down_data, vecs[0].dout[k]);
      @(posedge clk); #1;
    end
    down_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp hold data c%0d", c), down_data, P3);
      chk($sformatf("bp hold last c%0d", c), 64'(down_last), 64'(0));
      chk($sformatf("bp hold valid c%0d", c), 64'(down_valid), 64'(1));
      chk($sformatf("bp hold up_ready c%0d", c), 64'(up_ready), 64'(0));
      @(posedge clk); #1;
    end
    down_ready = 1'b1;
    drain_from(vecs[0], 2, "bp");

    // Reset in the 4th SORT cycle, then a fresh reversed batch.
    push4(vecs[5], "rs_pre");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    chk("rs in_sort up_ready", 64'(up_ready), 64'(0));
    rst = 1'b1;
    #1;
    chk("rs up_ready", 64'(up_ready), 64'(1));
    chk("rs down_valid", 64'(down_valid), 64'(0));
    chk("rs down_data", down_data, 64'(0));
    chk("rs down_last", 64'(down_last), 64'(0));
    chk("rs err", 64'(err), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    load_batch(vecs[5], "rs");
    drain_from(vecs[5], 0, "rs");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
